// File: rtl/menu_pkg.sv
// Shared types for the menu sequencer: screen states, menu_sel codes and cursor width.
package menu_pkg;

  localparam int CURSOR_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    M_MODO   = 3'd1,
    M_BPM    = 3'd2,
    M_TOM    = 3'd3,
    M_MUSICA = 3'd4,
    FIM      = 3'd5
  } estado_t;

  localparam logic [2:0] SEL_IDLE   = 3'd0;
  localparam logic [2:0] SEL_MODO   = 3'd1;
  localparam logic [2:0] SEL_BPM    = 3'd2;
  localparam logic [2:0] SEL_TOM    = 3'd3;
  localparam logic [2:0] SEL_MUSICA = 3'd4;
  localparam logic [2:0] SEL_FIM    = 3'd5;

  // Screen code shown to the display/Arduino link for a given state.
  function automatic logic [2:0] sel_of(input estado_t st);
    logic [2:0] sel;
    case (st)
      IDLE:     sel = SEL_IDLE;
      M_MODO:   sel = SEL_MODO;
      M_BPM:    sel = SEL_BPM;
      M_TOM:    sel = SEL_TOM;
      M_MUSICA: sel = SEL_MUSICA;
      FIM:      sel = SEL_FIM;
      default:  sel = SEL_IDLE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// One-bit rising-edge detector: remembers last cycle's level and flags a 0->1 change.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic sinal_q;
  logic sinal_d;

  // Previous level follows the input every cycle.
  always_comb begin
    sinal_d = sinal;
  end

  // Previous-level register, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sinal_q <= 1'b0;
    end else begin
      sinal_q <= sinal_d;
    end
  end

  assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/menu_configurador.sv
// Menu sequencer: mode -> BPM -> tone -> song, one-hot commits, completion pulse.
// Optional inactivity abort is enabled with the MENU_TIMEOUT_EN macro.
module menu_configurador
  import menu_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int MODO       = 6,
  parameter int BPM        = 2,
  parameter int TOM        = 4,
  parameter int MUSICA     = 16,
  parameter logic [MODO-1:0] SEM_MUSICA = 6'b100000,
  parameter int TIMEOUT_S  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inicia_menu,
  input  logic              right_arrow_pressed,
  input  logic              left_arrow_pressed,
  input  logic              enter_pressed,
  output logic [2:0]        menu_sel,
  output logic [CURSOR_W-1:0] cursor,
  output logic [MODO-1:0]   modos_reg,
  output logic [BPM-1:0]    bpm_reg,
  output logic [TOM-1:0]    tom_reg,
  output logic [MUSICA-1:0] musica_reg,
  output logic              mostra_menu,
  output logic              config_pronta,
  output logic              cancelado
);

  localparam logic [CURSOR_W-1:0] LAST_MODO   = CURSOR_W'(MODO - 1);
  localparam logic [CURSOR_W-1:0] LAST_BPM    = CURSOR_W'(BPM - 1);
  localparam logic [CURSOR_W-1:0] LAST_TOM    = CURSOR_W'(TOM - 1);
  localparam logic [CURSOR_W-1:0] LAST_MUSICA = CURSOR_W'(MUSICA - 1);
  localparam int TIMEOUT_CYC = CLOCK_FREQ * TIMEOUT_S;

  estado_t state_q, state_d;
  logic [CURSOR_W-1:0] cursor_q, cursor_d;
  logic [MODO-1:0]   modos_q, modos_d;
  logic [BPM-1:0]    bpm_q, bpm_d;
  logic [TOM-1:0]    tom_q, tom_d;
  logic [MUSICA-1:0] musica_q, musica_d;
  logic cancelado_q, cancelado_d;
  logic [CURSOR_W-1:0] last_s;
  logic right_s, left_s, enter_s;
  logic menu_ativo_s, timeout_s;

  detector_borda u_borda_right (.clock(clock), .reset(reset), .sinal(right_arrow_pressed), .borda(right_s));
  detector_borda u_borda_left  (.clock(clock), .reset(reset), .sinal(left_arrow_pressed),  .borda(left_s));
  detector_borda u_borda_enter (.clock(clock), .reset(reset), .sinal(enter_pressed),       .borda(enter_s));

  assign menu_ativo_s = (state_q == M_MODO) || (state_q == M_BPM) ||
                        (state_q == M_TOM)  || (state_q == M_MUSICA);

`ifdef MENU_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic atividade_s;

  // Any key edge or restart counts as activity; enter also implies a state change.
  always_comb begin
    atividade_s = right_s | left_s | enter_s | inicia_menu;
    timeout_s   = menu_ativo_s && (tmr_q == TMR_LAST) && !atividade_s;
    if (!menu_ativo_s || atividade_s || timeout_s) begin
      tmr_d = {TMR_W{1'b0}};
    end else begin
      tmr_d = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
    end
  end

  // Inactivity counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmr_q <= {TMR_W{1'b0}};
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
  assign timeout_s = 1'b0;
`endif

  // Size of the menu currently on screen, as its highest cursor index.
  always_comb begin
    case (state_q)
      M_MODO:   last_s = LAST_MODO;
      M_BPM:    last_s = LAST_BPM;
      M_TOM:    last_s = LAST_TOM;
      M_MUSICA: last_s = LAST_MUSICA;
      default:  last_s = {CURSOR_W{1'b0}};
    endcase
  end

  // Next-state, cursor movement and one-hot commit.
  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    modos_d     = modos_q;
    bpm_d       = bpm_q;
    tom_d       = tom_q;
    musica_d    = musica_q;
    cancelado_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (inicia_menu) begin
          state_d  = M_MODO;
          cursor_d = {CURSOR_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      M_MODO, M_BPM, M_TOM, M_MUSICA: begin
        if (timeout_s) begin
          state_d     = IDLE;
          cursor_d    = {CURSOR_W{1'b0}};
          cancelado_d = 1'b1;
        end else if (inicia_menu) begin
          state_d  = M_MODO;
          cursor_d = {CURSOR_W{1'b0}};
        end else if (enter_s) begin
          cursor_d = {CURSOR_W{1'b0}};
          case (state_q)
            M_MODO: begin
              modos_d = MODO'(1) << cursor_q;
              state_d = M_BPM;
            end
            M_BPM: begin
              bpm_d   = BPM'(1) << cursor_q;
              state_d = M_TOM;
            end
            M_TOM: begin
              tom_d = TOM'(1) << cursor_q;
              // The mode was committed earlier in this pass; songless modes finish here.
              if ((modos_q & SEM_MUSICA) != {MODO{1'b0}}) begin
                state_d = FIM;
              end else begin
                state_d = M_MUSICA;
              end
            end
            M_MUSICA: begin
              musica_d = MUSICA'(1) << cursor_q;
              state_d  = FIM;
            end
            default: state_d = IDLE;
          endcase
        end else if (right_s && !left_s) begin
          cursor_d = (cursor_q == last_s) ? {CURSOR_W{1'b0}} : cursor_q + {{(CURSOR_W-1){1'b0}}, 1'b1};
        end else if (left_s && !right_s) begin
          cursor_d = (cursor_q == {CURSOR_W{1'b0}}) ? last_s : cursor_q - {{(CURSOR_W-1){1'b0}}, 1'b1};
        end else begin
          cursor_d = cursor_q;
        end
      end
      FIM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, cursor and configuration registers; committed choices reset to index 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cursor_q    <= {CURSOR_W{1'b0}};
      modos_q     <= MODO'(1);
      bpm_q       <= BPM'(1);
      tom_q       <= TOM'(1);
      musica_q    <= MUSICA'(1);
      cancelado_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      modos_q     <= modos_d;
      bpm_q       <= bpm_d;
      tom_q       <= tom_d;
      musica_q    <= musica_d;
      cancelado_q <= cancelado_d;
    end
  end

  assign menu_sel      = sel_of(state_q);
  assign cursor        = cursor_q;
  assign modos_reg     = modos_q;
  assign bpm_reg       = bpm_q;
  assign tom_reg       = tom_q;
  assign musica_reg    = musica_q;
  assign mostra_menu   = menu_ativo_s;
  assign config_pronta = (state_q == FIM);
  assign cancelado     = cancelado_q;

endmodule

// File: tb/tb_menu_configurador.sv
// Scoreboard bench for menu_configurador: the driver pushes hand-computed snapshots,
// a negedge monitor pops and compares them and counts completion/abort pulses.
module tb_menu_configurador;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic inicia_menu = 1'b0;
  logic right_arrow_pressed = 1'b0;
  logic left_arrow_pressed = 1'b0;
  logic enter_pressed = 1'b0;
  logic [2:0]  menu_sel;
  logic [3:0]  cursor;
  logic [5:0]  modos_reg;
  logic [1:0]  bpm_reg;
  logic [3:0]  tom_reg;
  logic [15:0] musica_reg;
  logic mostra_menu, config_pronta, cancelado;

  menu_configurador #(.CLOCK_FREQ(100), .TIMEOUT_S(1)) dut (
    .clock(clock), .reset(reset), .inicia_menu(inicia_menu),
    .right_arrow_pressed(right_arrow_pressed), .left_arrow_pressed(left_arrow_pressed),
    .enter_pressed(enter_pressed), .menu_sel(menu_sel), .cursor(cursor),
    .modos_reg(modos_reg), .bpm_reg(bpm_reg), .tom_reg(tom_reg), .musica_reg(musica_reg),
    .mostra_menu(mostra_menu), .config_pronta(config_pronta), .cancelado(cancelado)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic [2:0]  sel;
    logic [3:0]  cur;
    logic [5:0]  mo;
    logic [1:0]  bp;
    logic [3:0]  tm;
    logic [15:0] mu;
    logic        most;
    logic        pr;
    logic        ca;
    int          np;
    int          nc;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int n_vec = 0;
  int n_miss = 0;
  int seen_np = 0;
  int seen_nc = 0;
  int exp_np = 0;
  int exp_nc = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [2:0] sel, input logic [3:0] cur,
                            input logic [5:0] mo, input logic [1:0] bp, input logic [3:0] tm,
                            input logic [15:0] mu, input logic pr, input logic ca);
    exp_t x;
    x.nm = nm; x.sel = sel; x.cur = cur; x.mo = mo; x.bp = bp; x.tm = tm; x.mu = mu;
    x.most = (sel >= 3'd1) && (sel <= 3'd4);
    x.pr = pr; x.ca = ca; x.np = exp_np; x.nc = exp_nc;
    sb_q.push_back(x);
  endtask

  // Monitor: count pulses seen, then check every pending expectation.
  always @(negedge clock) begin
    if (config_pronta === 1'b1) seen_np = seen_np + 1;
    if (cancelado === 1'b1) seen_nc = seen_nc + 1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec = n_vec + 1;
      if (menu_sel !== e.sel || cursor !== e.cur || modos_reg !== e.mo || bpm_reg !== e.bp ||
          tom_reg !== e.tm || musica_reg !== e.mu || mostra_menu !== e.most ||
          config_pronta !== e.pr || cancelado !== e.ca || seen_np != e.np || seen_nc != e.nc) begin
        n_miss = n_miss + 1;
        $display("FAIL %s: got sel=%0d cur=%0d modo=%b bpm=%b tom=%b mus=%h most=%b pr=%b ca=%b npr=%0d nca=%0d; want sel=%0d cur=%0d modo=%b bpm=%b tom=%b mus=%h most=%b pr=%b ca=%b npr=%0d nca=%0d",
                 e.nm, menu_sel, cursor, modos_reg, bpm_reg, tom_reg, musica_reg, mostra_menu,
                 config_pronta, cancelado, seen_np, seen_nc, e.sel, e.cur, e.mo, e.bp, e.tm,
                 e.mu, e.most, e.pr, e.ca, e.np, e.nc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    repeat (10) tick();
    expect_out("reset_idle", 3'd0, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0001, 1'b0, 1'b0);

    inicia_menu = 1'b1; tick(); inicia_menu = 1'b0;
    expect_out("start", 3'd1, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0001, 1'b0, 1'b0);
    left_arrow_pressed = 1'b1; tick();
    expect_out("modo_left_wrap", 3'd1, 4'd5, 6'b000001, 2'b01, 4'b0001, 16'h0001, 1'b0, 1'b0);
    left_arrow_pressed = 1'b0; tick();
    enter_pressed = 1'b1; tick();
    expect_out("modo_commit", 3'd2, 4'd0, 6'b100000, 2'b01, 4'b0001, 16'h0001, 1'b0, 1'b0);
    enter_pressed = 1'b0; tick();
    right_arrow_pressed = 1'b1; tick();
    expect_out("bpm_right", 3'd2, 4'd1, 6'b100000, 2'b01, 4'b0001, 16'h0001, 1'b0, 1'b0);
    right_arrow_pressed = 1'b0; tick();
    enter_pressed = 1'b1; tick();
    expect_out("bpm_commit", 3'd3, 4'd0, 6'b100000, 2'b10, 4'b0001, 16'h0001, 1'b0, 1'b0);
    enter_pressed = 1'b0; tick();
    left_arrow_pressed = 1'b1; tick();
    expect_out("tom_left_wrap", 3'd3, 4'd3, 6'b100000, 2'b10, 4'b0001, 16'h0001, 1'b0, 1'b0);
    left_arrow_pressed = 1'b0; tick();
    enter_pressed = 1'b1; tick();
    exp_np = 1;
    expect_out("tom_commit_skip_song", 3'd5, 4'd0, 6'b100000, 2'b10, 4'b1000, 16'h0001, 1'b1, 1'b0);
    enter_pressed = 1'b0; tick();
    expect_out("fim_to_idle", 3'd0, 4'd0, 6'b100000, 2'b10, 4'b1000, 16'h0001, 1'b0, 1'b0);

    inicia_menu = 1'b1; tick(); inicia_menu = 1'b0;
    expect_out("restart_keeps_regs", 3'd1, 4'd0, 6'b100000, 2'b10, 4'b1000, 16'h0001, 1'b0, 1'b0);
    repeat (3) begin
      enter_pressed = 1'b1; tick();
      enter_pressed = 1'b0; tick();
    end
    expect_out("mode0_to_song", 3'd4, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0001, 1'b0, 1'b0);
    repeat (17) begin
      right_arrow_pressed = 1'b1; tick();
      right_arrow_pressed = 1'b0; tick();
    end
    expect_out("song_right17_wrap", 3'd4, 4'd1, 6'b000001, 2'b01, 4'b0001, 16'h0001, 1'b0, 1'b0);
    enter_pressed = 1'b1; tick();
    exp_np = 2;
    expect_out("song_commit", 3'd5, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b1, 1'b0);
    enter_pressed = 1'b0; tick();
    expect_out("song_fim_to_idle", 3'd0, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);

    inicia_menu = 1'b1; tick(); inicia_menu = 1'b0;
    enter_pressed = 1'b1; tick();
    expect_out("modo_again", 3'd2, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);
    enter_pressed = 1'b0; tick();
    enter_pressed = 1'b1; right_arrow_pressed = 1'b1; tick();
    expect_out("enter_beats_right", 3'd3, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);
    enter_pressed = 1'b0; right_arrow_pressed = 1'b0; tick();
    right_arrow_pressed = 1'b1;
    repeat (60) tick();
    expect_out("right_held_once", 3'd3, 4'd1, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);
    right_arrow_pressed = 1'b0; tick();
    left_arrow_pressed = 1'b1; tick();
    expect_out("tom_left", 3'd3, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);
    left_arrow_pressed = 1'b0;
    repeat (99) tick();
    expect_out("pre_timeout", 3'd3, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);
    tick();
`ifdef MENU_TIMEOUT_EN
    exp_nc = 1;
    expect_out("timeout_abort", 3'd0, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b1);
    tick();
    expect_out("timeout_pulse_end", 3'd0, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);
`else
    expect_out("no_timeout", 3'd3, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);
    tick();
    expect_out("still_waiting", 3'd3, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);
`endif

    inicia_menu = 1'b1; tick(); inicia_menu = 1'b0;
    expect_out("restart_menu", 3'd1, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);
    right_arrow_pressed = 1'b1; tick();
    expect_out("modo_right", 3'd1, 4'd1, 6'b000001, 2'b01, 4'b0001, 16'h0002, 1'b0, 1'b0);
    right_arrow_pressed = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    expect_out("reset_mid_menu", 3'd0, 4'd0, 6'b000001, 2'b01, 4'b0001, 16'h0001, 1'b0, 1'b0);

    repeat (3) @(negedge clock);
    #1;
    if (n_vec != 24) begin
        n_miss = n_miss + 1;
        $display("FAIL vector_count: applied %0d, want 24", n_vec);
    end
    if (seen_np != exp_np || seen_nc != exp_nc) begin
        n_miss = n_miss + 1;
        $display("FAIL pulse_totals: npr=%0d nca=%0d, want npr=%0d nca=%0d", seen_np, seen_nc, exp_np, exp_nc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_miss != 0) begin
        $display("FAIL: %0d miscompares", n_miss);
    end else begin
        $display("PASS");
    end
    $finish;
  end

endmodule
